// File: rtl/vga_ctrl.sv
// VGA 640x480@60 timing generator with one-cycle-ahead pixel request and blanked RGB output.
// Latency: hsync/vsync/pix_x/pix_y/rgb are combinational from the counters; frame_start is registered one cycle.
// Backpressure: none; free-running raster, the pattern stage must answer every request one cycle later.
//
// Ports:
//   vga_clk     - pixel clock (only clock)
//   sys_rst     - synchronous active-high reset
//   pix_data    - RGB565 colour from the pattern stage, one cycle after pix_x/pix_y
//   pix_x/pix_y - requested pixel coordinate, 10'h3FF outside the request window
//   hsync/vsync - active-low sync pulses
//   rgb         - colour to the DAC, zero outside the visible area
//   frame_start - one-cycle pulse at the frame origin (not for the first frame after reset)

module vga_ctrl #(
    parameter logic [9:0] H_SYNC  = 10'd96,
    parameter logic [9:0] H_BACK  = 10'd48,
    parameter logic [9:0] H_VALID = 10'd640,
    parameter logic [9:0] H_FRONT = 10'd16,
    parameter logic [9:0] V_SYNC  = 10'd2,
    parameter logic [9:0] V_BACK  = 10'd33,
    parameter logic [9:0] V_VALID = 10'd480,
    parameter logic [9:0] V_FRONT = 10'd10
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        frame_start
);

    localparam logic [9:0] H_TOTAL     = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam logic [9:0] V_TOTAL     = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
    localparam logic [9:0] H_ACT_END   = H_ACT_START + H_VALID;
    localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
    localparam logic [9:0] V_ACT_END   = V_ACT_START + V_VALID;
    // Request window leads the visible window by one cycle to cover pattern-stage latency.
    localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
    localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;
    logic       v_win;
    logic       rgb_valid;
    logic       pix_data_req;

    assign h_last = (h_cnt == H_TOTAL - 10'd1);
    assign v_last = (v_cnt == V_TOTAL - 10'd1);

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end
            // Only a real wrap pulses, so the frame leaving reset gets no pulse.
            frame_start <= h_last && v_last;
        end
    end

    assign hsync = (h_cnt >= H_SYNC);
    assign vsync = (v_cnt >= V_SYNC);

    assign v_win        = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    assign rgb_valid    = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) && v_win;
    assign pix_data_req = (h_cnt >= H_REQ_START) && (h_cnt < H_REQ_END) && v_win;

    // Subtractions cannot underflow: they are only used inside the request window.
    assign pix_x = pix_data_req ? (h_cnt - H_REQ_START) : 10'h3FF;
    assign pix_y = pix_data_req ? (v_cnt - V_ACT_START) : 10'h3FF;

    assign rgb = rgb_valid ? pix_data : 16'h0000;

endmodule
